// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if: UART byte handshakes plus memory bus seen by the UART bus master
// Members:
//    rx_done/rx_data                 byte strobe and data from uart_rx
//    tx_en/tx_data/tx_done           byte request and completion handshake with uart_tx
//    Address/Write_data/Read_data    shared data-memory bus
//    MemWrite/MemRead                one-cycle bus strobes
//    busy                            CPU stall request
//    frame_err                       sticky protocol error flag
// The master modport is the bus master. The slave modport is its environment.
interface uart_bus_master_if;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Read_data;
   logic        busy;
   logic        frame_err;
   modport master (
      input  rx_done, rx_data, tx_done, Read_data,
      output tx_en, tx_data, Address, Write_data, MemWrite, MemRead, busy, frame_err
   );
   modport slave (
      output rx_done, rx_data, tx_done, Read_data,
      input  tx_en, tx_data, Address, Write_data, MemWrite, MemRead, busy, frame_err
   );
endinterface

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command decoder that issues single-word bus writes/reads and replies over UART
// Ports:
//    clk    system clock; all logic runs on its rising edge
//    reset  asynchronous active-low reset
//    bus    uart_bus_master_if.master, which carries the rx/tx handshakes, memory bus, busy and frame_err
// Frames (fields MSB first):
//    'W' A3..A0 D3..D0 -> write, ACK
//    'R' A3..A0        -> read, Q3..Q0
//    other             -> NAK
// Define UART_BUS_MASTER_AUTOINC_EN to add 'N' D3..D0, which writes to last_addr+4.
module uart_bus_master #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B,
   parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
   input logic                clk,
   input logic                reset,
   uart_bus_master_if.master  bus
);
   typedef enum logic [3:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, RD_CAP, TX_REQ, TX_WAIT} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d, tx_data_q, tx_data_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  pend_q, pend_d;
   logic [23:0] tmo_q, tmo_d;
   logic [31:0] addr_q, addr_d, data_q, data_d, address_q, address_d, write_data_q, write_data_d;
   logic        tx_en_q, tx_en_d, mem_write_q, mem_write_d, mem_read_q, mem_read_d;
   logic        busy_q, busy_d, frame_err_q, frame_err_d;
`ifdef UART_BUS_MASTER_AUTOINC_EN
   logic [31:0] last_addr_q, last_addr_d;
`endif
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      tmo_d        = '0;
      addr_d       = addr_q;
      data_d       = data_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      tx_data_d    = tx_data_q;
      tx_en_d      = tx_en_q;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      frame_err_d  = frame_err_q;
`ifdef UART_BUS_MASTER_AUTOINC_EN
      last_addr_d  = last_addr_q;
`endif
      case (state_q)
         IDLE: if (bus.rx_done) begin
            cmd_d = bus.rx_data;
            cnt_d = '0;
            if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) state_d = GET_ADDR;
`ifdef UART_BUS_MASTER_AUTOINC_EN
            else if (bus.rx_data == 8'h4E) begin
               addr_d  = last_addr_q + 32'd4;
               state_d = GET_DATA;
            end
`endif
            else begin
               data_d  = {NAK_BYTE, 24'h0};
               pend_d  = 3'd1;
               state_d = TX_REQ;
            end
         end
         GET_ADDR, GET_DATA: if (bus.rx_done) begin
            cnt_d = cnt_q + 2'd1;
            if (state_q == GET_ADDR) addr_d = {addr_q[23:0], bus.rx_data};
            else data_d = {data_q[23:0], bus.rx_data};
            // The 2-bit count wraps to 0 on the fourth byte, which also ends the field.
            if (cnt_q == 2'd3) state_d = (state_q == GET_DATA) ? BUS_WR : (cmd_q == 8'h52) ? BUS_RD : GET_DATA;
         end else if (tmo_q == TIMEOUT_CYCLES) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
         end else tmo_d = tmo_q + 24'd1;
         BUS_WR: begin
            mem_write_d  = 1'b1;
            address_d    = addr_q;
            write_data_d = data_q;
            data_d       = {ACK_BYTE, 24'h0};
            pend_d       = 3'd1;
            state_d      = TX_REQ;
`ifdef UART_BUS_MASTER_AUTOINC_EN
            last_addr_d  = addr_q;
`endif
         end
         BUS_RD: begin
            mem_read_d  = 1'b1;
            address_d   = addr_q;
            state_d     = RD_WAIT;
`ifdef UART_BUS_MASTER_AUTOINC_EN
            last_addr_d = addr_q;
`endif
         end
         RD_WAIT: state_d = RD_CAP;
         // The memory registers the Address driven one edge earlier, so Read_data is valid here.
         RD_CAP: begin
            data_d  = bus.Read_data;
            pend_d  = 3'd4;
            state_d = TX_REQ;
         end
         TX_REQ: begin
            tx_data_d = data_q[31:24];
            tx_en_d   = 1'b1;
            state_d   = TX_WAIT;
         end
         TX_WAIT: if (bus.tx_done) begin
            tx_en_d = 1'b0;
            pend_d  = pend_q - 3'd1;
            data_d  = {data_q[23:0], 8'h0};
            state_d = (pend_q == 3'd1) ? IDLE : TX_REQ;
         end
         default: state_d = IDLE;
      endcase
      // A byte that arrives while a bus cycle or reply is in progress has nowhere to go.
      if (bus.rx_done && !(state_q inside {IDLE, GET_ADDR, GET_DATA})) frame_err_d = 1'b1;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         cnt_q        <= '0;
         pend_q       <= '0;
         tmo_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         address_q    <= '0;
         write_data_q <= '0;
         tx_data_q    <= '0;
         tx_en_q      <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_BUS_MASTER_AUTOINC_EN
         last_addr_q  <= 32'hFFFF_FFFC;
`endif
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         tmo_q        <= tmo_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         tx_data_q    <= tx_data_d;
         tx_en_q      <= tx_en_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         busy_q       <= busy_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_BUS_MASTER_AUTOINC_EN
         last_addr_q  <= last_addr_d;
`endif
      end
   end
   assign bus.tx_en      = tx_en_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.Address    = address_q;
   assign bus.Write_data = write_data_q;
   assign bus.MemWrite   = mem_write_q;
   assign bus.MemRead    = mem_read_q;
   assign bus.busy       = busy_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: randomized frame-level check of uart_bus_master against a protocol reference model
module tb_uart_bus_master;
   localparam logic [23:0] TMO = 24'd100;
   localparam logic [7:0]  ACK = 8'h4B;
   localparam logic [7:0]  NAK = 8'h3F;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [31:0] wr_a = '0;
   logic [31:0] wr_d = '0;
   logic [7:0] txq[$];
   logic [7:0] exp_tx[$];
   logic [7:0] fr[$];
   logic exp_ferr = 1'b0;
   logic [31:0] last_addr = 32'hFFFF_FFFC;
   uart_bus_master_if bus();
   uart_bus_master #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (.clk(clk), .reset(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h4000_0014) ? 32'h1234_5678 : ({a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F);
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Registered memory, plus strobe counters.
   always @(posedge clk) begin
      bus.Read_data <= mem_val(bus.Address);
      if (bus.MemWrite) begin
         wr_cnt <= wr_cnt + 1;
         wr_a   <= bus.Address;
         wr_d   <= bus.Write_data;
      end
      if (bus.MemRead) rd_cnt <= rd_cnt + 1;
   end
   // uart_tx stand-in: accept each requested byte after a random delay.
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_en) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            txq.push_back(bus.tx_data);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            check("tx_gap", {31'h0, bus.tx_en}, 32'h0);
         end
      end
   end
   task automatic do_reset();
      rst_n = 1'b0;
      bus.rx_done = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_ferr = 1'b0;
      last_addr = 32'hFFFF_FFFC;
      @(negedge clk);
   endtask
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask
   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && bus.busy; i++) @(negedge clk);
      check(tag, {31'h0, bus.busy}, 32'h0);
   endtask
   task automatic check_zero_outputs(input string tag);
      check({tag, "_addr"}, bus.Address, 32'h0);
      check({tag, "_wdata"}, bus.Write_data, 32'h0);
      check({tag, "_strobes"}, {30'h0, bus.MemWrite, bus.MemRead}, 32'h0);
      check({tag, "_tx"}, {23'h0, bus.tx_en, bus.tx_data}, 32'h0);
      check({tag, "_busy_ferr"}, {30'h0, bus.busy, bus.frame_err}, 32'h0);
   endtask
   // Reference model: derive the bus effect and reply bytes of a whole frame, then send it and compare.
   task automatic run_frame(input logic [7:0] f[$]);
      int w0, r0;
      logic ew, er;
      logic [31:0] wa, wd, q;
      w0 = wr_cnt;
      r0 = rd_cnt;
      ew = 1'b0;
      er = 1'b0;
      wa = '0;
      wd = '0;
      exp_tx.delete();
      txq.delete();
      if (f[0] == 8'h57 && f.size() == 9) begin
         ew = 1'b1;
         wa = {f[1], f[2], f[3], f[4]};
         wd = {f[5], f[6], f[7], f[8]};
         exp_tx.push_back(ACK);
         last_addr = wa;
      end else if (f[0] == 8'h52 && f.size() == 5) begin
         er = 1'b1;
         wa = {f[1], f[2], f[3], f[4]};
         q = mem_val(wa);
         for (int i = 3; i >= 0; i--) exp_tx.push_back(q[i*8 +: 8]);
         last_addr = wa;
      end
`ifdef UART_BUS_MASTER_AUTOINC_EN
      else if (f[0] == 8'h4E && f.size() == 5) begin
         ew = 1'b1;
         wa = last_addr + 32'd4;
         wd = {f[1], f[2], f[3], f[4]};
         exp_tx.push_back(ACK);
         last_addr = wa;
      end
`endif
      else exp_tx.push_back(NAK);
      foreach (f[i]) send_byte(f[i]);
      wait_idle("frame_idle", 2000);
      check("wr_count", wr_cnt - w0, {31'h0, ew});
      check("rd_count", rd_cnt - r0, {31'h0, er});
      if (ew) begin
         check("wr_addr", wr_a, wa);
         check("wr_data", wr_d, wd);
      end
      check("tx_len", txq.size(), exp_tx.size());
      foreach (exp_tx[i]) check("tx_byte", (i < txq.size()) ? {24'h0, txq[i]} : 32'hDEAD, {24'h0, exp_tx[i]});
      check("tx_en_end", {31'h0, bus.tx_en}, 32'h0);
      check("frame_err", {31'h0, bus.frame_err}, {31'h0, exp_ferr});
   endtask
   initial begin
      int w0;
      logic [31:0] r;
      bus.rx_done = 1'b0;
      bus.rx_data = '0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      do_reset();
      fr = {8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_frame(fr);
      fr = {8'h52, 8'h40, 8'h00, 8'h00, 8'h14};
      run_frame(fr);
      fr = {8'h00};
      run_frame(fr);
`ifndef UART_BUS_MASTER_AUTOINC_EN
      fr = {8'h4E};
      run_frame(fr);
`endif
      for (int k = 0; k < 24; k++) begin
         int sel;
         logic [7:0] c;
         sel = $urandom_range(0, 2);
         fr.delete();
         if (sel == 2) begin
            do c = 8'($urandom_range(0, 255)); while (c == 8'h57 || c == 8'h52 || c == 8'h4E);
            fr.push_back(c);
         end else begin
            fr.push_back(sel == 0 ? 8'h57 : 8'h52);
            r = $urandom;
            for (int i = 3; i >= 0; i--) fr.push_back(r[i*8 +: 8]);
            r = $urandom;
            if (sel == 0) for (int i = 3; i >= 0; i--) fr.push_back(r[i*8 +: 8]);
         end
         run_frame(fr);
      end
      // A byte that arrives during the reply is dropped and flagged, and the reply is unaffected.
      do_reset();
      w0 = rd_cnt;
      txq.delete();
      fr = {8'h52, 8'h40, 8'h00, 8'h00, 8'h14};
      foreach (fr[i]) send_byte(fr[i]);
      for (int i = 0; i < 200 && !bus.tx_en; i++) @(negedge clk);
      check("drop_tx_en", {31'h0, bus.tx_en}, 32'h1);
      send_byte(8'h57);
      wait_idle("drop_idle", 2000);
      check("drop_ferr", {31'h0, bus.frame_err}, 32'h1);
      check("drop_rd_count", rd_cnt - w0, 32'h1);
      check("drop_tx_len", txq.size(), 32'd4);
      r = {txq[0], txq[1], txq[2], txq[3]};
      check("drop_rdata", r, 32'h1234_5678);
      // An asynchronous reset mid-GET_DATA clears every output before the next clock edge.
      fr = {8'h57, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      foreach (fr[i]) send_byte(fr[i]);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      exp_ferr = 1'b0;
      last_addr = 32'hFFFF_FFFC;
      fr = {8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(fr);
      // Silence inside a frame times out with no bus cycle, and the next frame still works.
      w0 = wr_cnt;
      fr = {8'h57, 8'h00, 8'h00};
      foreach (fr[i]) send_byte(fr[i]);
      repeat (int'(TMO) + 20) @(negedge clk);
      check("tmo_busy", {31'h0, bus.busy}, 32'h0);
      check("tmo_ferr", {31'h0, bus.frame_err}, 32'h1);
      check("tmo_no_write", wr_cnt - w0, 32'h0);
      exp_ferr = 1'b1;
      fr = {8'h57, 8'hCA, 8'hFE, 8'h00, 8'h08, 8'h87, 8'h65, 8'h43, 8'h21};
      run_frame(fr);
`ifdef UART_BUS_MASTER_AUTOINC_EN
      do_reset();
      fr = {8'h4E, 8'h00, 8'h00, 8'h00, 8'h01};
      run_frame(fr);
      fr = {8'h4E, 8'h00, 8'h00, 8'h00, 8'h02};
      run_frame(fr);
      fr = {8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
      run_frame(fr);
      fr = {8'h4E, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_frame(fr);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven bus initiator: it is the host-side master for the data memory / peripheral bus.
- Takes bytes from a uart_rx instance and decodes a small command protocol.
- Issues single-word MemWrite/MemRead cycles on the same Address/Write_data/Read_data bus the CPU uses, and returns acks or read data through a uart_tx instance.
- Used for program/data loading and debug peeks while the CPU is held via busy.

Parameters:
- TIMEOUT_CYCLES, 24'd1000000: max idle clk cycles between bytes of one frame before the frame is abandoned.
- ACK_BYTE, 8'h4B: byte sent after a completed write.
- NAK_BYTE, 8'h3F: byte sent for an unknown command byte.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- rx_done  in  1  one-cycle pulse from uart_rx: rx_data valid.
- rx_data  in  8  received byte.
- tx_en  out  1  level request to uart_tx; held until tx_done.
- tx_data  out  8  byte to send; stable while tx_en=1.
- tx_done  in  1  one-cycle pulse from uart_tx: byte sent.
- Address  out  32  bus address.
- Write_data  out  32  bus write data.
- MemWrite  out  1  one-cycle write strobe.
- MemRead  out  1  one-cycle read strobe.
- Read_data  in  32  registered memory output; valid 1 cycle after the Address cycle.
- busy  out  1  high in any state except IDLE; the CPU stalls on it.
- frame_err  out  1  sticky: timeout or rx byte dropped; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state IDLE, internal address/data/counters 0.
- All outputs are registered.
- Frame formats (multi-byte fields MSB first):
  - Write: 'W' (8'h57), A3..A0, D3..D0 -> bus write -> ACK_BYTE.
  - Read: 'R' (8'h52), A3..A0 -> bus read -> Q3..Q0.
  - Any other first byte -> NAK_BYTE; state returns to IDLE after it is sent.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, RD_CAP, TX_REQ, TX_WAIT.
- IDLE: on rx_done, latch the command. 'W'/'R' -> GET_ADDR with byte count 0; else load NAK -> TX_REQ.
- GET_ADDR/GET_DATA: shift each byte in (reg <= {reg[23:0], rx_data}). The fourth byte advances the state.
  - 'R' after the address -> BUS_RD.
  - 'W' after the address -> GET_DATA; after the data -> BUS_WR.
- BUS_WR: drive Address/Write_data and MemWrite=1 for exactly one cycle. Load ACK, go to TX_REQ with 1 byte pending.
- BUS_RD: drive Address and MemRead=1 for one cycle. RD_WAIT holds Address one more cycle. RD_CAP samples Read_data into the shift register and queues 4 bytes.
  - Read_data is sampled exactly 2 edges after the edge that first drives Address.
- Address and Write_data hold their values after a cycle; only the strobes drop.
- TX_REQ: tx_data <= top byte, tx_en <= 1, go to TX_WAIT.
- TX_WAIT: on tx_done, tx_en <= 0 (low for at least 1 cycle) and decrement the pending count.
  - Remaining bytes -> shift left 8, back to TX_REQ.
  - No bytes remaining -> IDLE.
- Timeout: the counter runs in GET_ADDR/GET_DATA and clears on each rx_done. When it reaches TIMEOUT_CYCLES: go to IDLE, set frame_err, no bus cycle.
- rx_done arriving in any bus/TX state: byte dropped, frame_err set, no state change.
- Address is not aligned or checked; the bus ignores bits [1:0].
- Async reset mid-frame or mid-transmit: immediately IDLE with tx_en=0 and no strobes. A partial uart_tx byte is the transmitter's concern.

Optional Feature:
- Macro UART_BUS_MASTER_AUTOINC_EN.
- Defined: command 'N' (8'h4E) takes D3..D0 only. It writes to last_addr+4, then updates last_addr and sends ACK_BYTE. Any 'W' sets last_addr, and so does 'R'. last_addr resets to 32'hFFFFFFFC, so the first 'N' writes 0x00000000.
- Undefined: 'N' is an unknown command -> NAK_BYTE. The last_addr register is absent.

Test Plan:
- Write: bytes 57 00 00 00 10 DE AD BE EF -> one cycle with MemWrite=1, Address=0x00000010, Write_data=0xDEADBEEF; then tx byte 0x4B; busy falls after tx_done.
- Read: model memory holds 0x12345678 at 0x40000014; bytes 52 40 00 00 14 -> MemRead pulse, sample 2 edges later, tx 12 34 56 78 in order; tx_en low ≥1 cycle between bytes.
- Unknown: byte 0x00 -> tx 0x3F, no MemRead/MemWrite ever, back to IDLE.
- Timeout: send 57 00 00, then silence for TIMEOUT_CYCLES (set 100 in bench) -> IDLE, frame_err=1, no strobe. A following complete 'W' frame still works.
- Drop + reset: send rx byte during TX_WAIT -> frame_err=1, read data unchanged. Pull reset low mid-GET_DATA -> all outputs 0 within the same cycle.
- AUTOINC (macro defined): 4E 00 00 00 01 then 4E 00 00 00 02 -> writes 0x1 @0x0 then 0x2 @0x4, two 0x4B acks.
